debug_flag_port: RTL

Avalon-MM slave peripheral that lets firmware publish 32-bit debug flag words (`{type, location, arg1, arg0}`) to the outside world. Writes are buffered in a small FIFO and replayed onto a registered `debug_wire` bus. Each flag is held for a guaranteed minimum number of cycles, so an external observer (simulation bench, logic analyzer, LEDR mirror) never misses a flag. It is instantiated inside the Qsys system next to the PULPino core, and its `debug_wire` is exported to the top level.

---
 rtl/debug_flag_port.sv | 127 ++++++++++++
 1 files changed

// File: rtl/debug_flag_port.sv
// Avalon-MM debug flag publisher: FLAG writes are queued in a small FIFO and
// replayed onto a registered debug_wire, each flag held for at least HOLD_CYCLES.
module debug_flag_port #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned STALL_ON_FULL = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [31:0] debug_wire,
  output logic        debug_valid,
  output logic [7:0]  debug_seq,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          full_q;
  logic          empty;
  state_t        state;
  logic [7:0]    hold_cnt;
  logic          flag_wr;
  logic          push;
  logic          pop;
  logic          drop;
  logic          ovf_clear;
  logic [31:0]   status;

  assign flag_wr   = avs_write && (avs_address == 2'd0);
  assign push      = flag_wr && !full_q;
  assign drop      = flag_wr && full_q && (STALL_ON_FULL == 0);
  assign ovf_clear = avs_write && (avs_address == 2'd1) && avs_writedata[16];
  assign empty     = (count == '0);
  // The FSM only sees registered FIFO state, so a fresh push is never bypassed.
  assign pop       = !empty && ((state == IDLE) || (hold_cnt == '0));

  assign avs_waitrequest = (STALL_ON_FULL != 0) && flag_wr && full_q;

  always_comb begin
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= avs_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == (AW+1)'(DEPTH));
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      debug_wire  <= '0;
      debug_valid <= 1'b0;
      debug_seq   <= '0;
    end else begin
      debug_valid <= pop;
      if (pop) begin
        debug_wire <= mem[rd_ptr];
        debug_seq  <= debug_seq + 8'd1;
        hold_cnt   <= 8'(HOLD_CYCLES - 1);
        state      <= HOLD;
      end else if (state == HOLD) begin
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 8'd1;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  always_comb begin
    status       = '0;
    status[5:0]  = 6'(count);
    status[8]    = full_q;
    status[9]    = empty;
    status[10]   = (state == HOLD);
    status[16]   = overflow;
    avs_readdata = '0;
    if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata = debug_wire;
        2'd1:    avs_readdata = status;
        2'd2:    avs_readdata = {24'b0, debug_seq};
        default: avs_readdata = '0;
      endcase
    end
  end

endmodule
